// File: rtl/period_meter.sv
// Rising-edge-to-rising-edge period of an async input, in tick units; valid SYNC_STAGES+1 clks after the rise (+FILTER_LEN with PERIOD_FILTER_EN).
// No backpressure: valid is a one-clk pulse and period/overflow hold until the next capture.
// Define PERIOD_FILTER_EN to add the glitch filter on the synchronized input.
module period_meter #(
    parameter int W           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         sig_in,
    input  logic         clear,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         overflow,
    output logic         timeout
);

    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam logic [0:0]   ST_IDLE  = 1'b0;
    localparam logic [0:0]   ST_MEAS  = 1'b1;

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("period_meter: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f;
    logic                   f_d;
    logic                   rise;
    logic [0:0]             state;
    logic [W-1:0]           cnt;
    logic [W:0]             sum;
    logic [W-1:0]           nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PERIOD_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [FCW-1:0] flt_cnt;
    logic           f_q;

    // f follows s only once s has disagreed with it for FILTER_LEN clks in a row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_q     <= 1'b0;
            flt_cnt <= '0;
        end else if (s == f_q) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
            f_q     <= s;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign f = f_q;
`else
    assign f = s;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_d <= 1'b0;
        end else begin
            f_d <= f;
        end
    end

    assign rise = f & ~f_d;

    // A tick landing in the edge cycle still belongs to the period being closed
    assign sum = {1'b0, cnt} + {{W{1'b0}}, tick};
    assign nxt = sum[W] ? CNT_MAX : sum[W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            period   <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clear) begin
                cnt   <= '0;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                        if (rise) begin
                            state <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (rise) begin
                            period   <= nxt;
                            overflow <= (nxt == CNT_MAX);
                            valid    <= 1'b1;
                            cnt      <= '0;
                        end else begin
                            cnt <= nxt;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // cnt is held at 0 outside MEAS, so saturation alone identifies a stalled input
    assign timeout = (cnt == CNT_MAX);

endmodule
